load_store_unit: RTL and testbench

- Execute/memory-stage block directly downstream of the ALU: takes the ALU result as the effective address, plus rs2 data and funct3, and runs one load or store on a single-port data-memory interface with a req/ack handshake.
- Handles byte-lane steering, byte enables, load sign/zero extension, misalignment and illegal-encoding detection.
- Returns a registered result to writeback with a one-cycle done pulse.

---
 rtl/load_store_unit.sv | 200 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: one load or store per request on a req/ack data-memory port, with lane
// steering, byte enables and load extension. Define LSU_TIMEOUT_EN to abort unacknowledged requests.
module load_store_unit #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic                  start,
   input  logic                  memRead,
   input  logic                  memWrite,
   input  logic [2:0]            funct3,
   input  logic [DATA_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] store_data,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] load_data,
   output logic                  error,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_be,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   if (DATA_WIDTH != 32) begin : g_bad_width
      $error("load_store_unit supports DATA_WIDTH == 32 only");
   end
   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [1:0] {StIdle, StReq, StFin} state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] load_q, load_d;
   logic [3:0]  be_q, be_d;
   logic [2:0]  funct3_q, funct3_d;
   logic        we_q, we_d;
   logic        err_q, err_d;

   logic        f3_legal, aligned;
   logic [3:0]  st_be;
   logic [31:0] st_wdata, ld_ext;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

`ifdef LSU_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CntW-1:0] cnt_q, cnt_d;
`endif

   // Request decode; a request with both or neither direction set is illegal.
   always_comb begin
      f3_legal = 1'b0;
      if (memRead && !memWrite) begin
         f3_legal = (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      end else if (memWrite && !memRead) begin
         f3_legal = !funct3[2] && (funct3[1:0] != 2'b11);
      end
      case (funct3[1:0])
         2'b01:   aligned = !addr[0];
         2'b10:   aligned = (addr[1:0] == 2'b00);
         default: aligned = 1'b1;
      endcase
   end

   always_comb begin
      st_be    = 4'b1111;
      st_wdata = store_data;
      if (memWrite) begin
         case (funct3[1:0])
            2'b00: begin
               st_wdata = {4{store_data[7:0]}};
               st_be    = 4'b0001 << addr[1:0];
            end
            2'b01: begin
               st_wdata = {2{store_data[15:0]}};
               st_be    = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      lane_b = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
      lane_h = mem_rdata[{addr_q[1], 4'b0000} +: 16];
      case (funct3_q)
         3'b000:  ld_ext = {{24{lane_b[7]}}, lane_b};
         3'b001:  ld_ext = {{16{lane_h[15]}}, lane_h};
         3'b100:  ld_ext = {24'h0, lane_b};
         3'b101:  ld_ext = {16'h0, lane_h};
         default: ld_ext = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      load_d   = load_q;
      be_d     = be_q;
      funct3_d = funct3_q;
      we_d     = we_q;
      err_d    = err_q;
`ifdef LSU_TIMEOUT_EN
      cnt_d    = cnt_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (f3_legal && aligned) begin
                  addr_d   = addr;
                  wdata_d  = st_wdata;
                  be_d     = st_be;
                  funct3_d = funct3;
                  we_d     = memWrite;
                  err_d    = 1'b0;
                  state_d  = StReq;
`ifdef LSU_TIMEOUT_EN
                  cnt_d    = '0;
`endif
               end else begin
                  err_d   = 1'b1;
                  state_d = StFin;
               end
            end
         end
         StReq: begin
            if (mem_ack) begin
               if (!we_q) load_d = ld_ext;
               err_d   = 1'b0;
               state_d = StFin;
`ifdef LSU_TIMEOUT_EN
            end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
               err_d   = 1'b1;
               state_d = StFin;
            end else begin
               cnt_d = cnt_q + CntW'(1);
`endif
            end
         end
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         load_q   <= '0;
         be_q     <= '0;
         funct3_q <= '0;
         we_q     <= 1'b0;
         err_q    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
         cnt_q    <= '0;
`endif
      end else begin
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         load_q   <= load_d;
         be_q     <= be_d;
         funct3_q <= funct3_d;
         we_q     <= we_d;
         err_q    <= err_d;
`ifdef LSU_TIMEOUT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   always_comb begin
      busy    = (state_q != StIdle);
      mem_req = (state_q == StReq);
      done    = (state_q == StFin);
      error   = (state_q == StFin) && err_q;
   end

   assign mem_addr  = {addr_q[31:2], 2'b00};
   assign mem_we    = we_q;
   assign mem_be    = be_q;
   assign mem_wdata = wdata_q;
   assign load_data = load_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table of single accesses plus hand-written
// sequences for busy-start, reset-in-flight and the no-ack / timeout behaviour.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rstN;
   logic        start, memRead, memWrite;
   logic [2:0]  funct3;
   logic [31:0] addr, store_data;
   logic        busy, done, error, mem_req, mem_we, mem_ack;
   logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;

   int n_vec = 0;
   int n_bad = 0;
   string tag;
   logic [31:0] ld_model = 32'h0;

   typedef struct {
      bit          rd;
      bit          wr;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] sdata;
      logic [31:0] rdata;
      int          waitc;
      bit          err;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] ld;
   } vec_t;

   vec_t vecs[$];

   load_store_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
      .clk        (clk),
      .rstN       (rstN),
      .start      (start),
      .memRead    (memRead),
      .memWrite   (memWrite),
      .funct3     (funct3),
      .addr       (addr),
      .store_data (store_data),
      .busy       (busy),
      .done       (done),
      .load_data  (load_data),
      .error      (error),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_be     (mem_be),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s.%s: got %h, expected %h", tag, nm, act, exp);
      end
   endtask

   task automatic add(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] sd, input logic [31:0] rdt, input int w, input bit err,
                      input logic [3:0] be, input logic [31:0] wd, input logic [31:0] ld);
      vec_t v;
      v.rd = rd; v.wr = wr; v.f3 = f3; v.a = a; v.sdata = sd; v.rdata = rdt; v.waitc = w;
      v.err = err; v.be = be; v.wdata = wd; v.ld = ld;
      vecs.push_back(v);
   endtask

   task automatic issue(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd);
      @(negedge clk);
      start = 1'b1; memRead = rd; memWrite = wr; funct3 = f3; addr = a; store_data = sd;
      @(negedge clk);
      start = 1'b0; memRead = 1'b0; memWrite = 1'b0;
   endtask

   task automatic ack_with(input logic [31:0] rdt);
      mem_ack = 1'b1; mem_rdata = rdt;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = 32'h5A5A_5A5A;
   endtask

   initial begin
      rstN = 1'b0; start = 1'b0; memRead = 1'b0; memWrite = 1'b0; funct3 = 3'b000;
      addr = 32'h0; store_data = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;

      //  rd wr f3      addr        sdata         rdata         wait err be       wdata         load
      add(1, 0, 3'b000, 32'h1003, 32'h0,        32'h80FF1234, 2, 0, 4'b1111, 32'h0,        32'hFFFFFF80);
      add(1, 0, 3'b101, 32'h2002, 32'h0,        32'hBEEF0001, 0, 0, 4'b1111, 32'h0,        32'h0000BEEF);
      add(0, 1, 3'b000, 32'h0031, 32'h123456AB, 32'h0,        0, 0, 4'b0010, 32'hABABABAB, 32'h0);
      add(0, 1, 3'b001, 32'h0032, 32'h123456AB, 32'h0,        1, 0, 4'b1100, 32'h56AB56AB, 32'h0);
      add(1, 0, 3'b010, 32'h0041, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0);
      add(1, 0, 3'b011, 32'h0040, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0);
      add(1, 1, 3'b010, 32'h0040, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0);
      add(0, 0, 3'b010, 32'h0040, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0);
      add(1, 0, 3'b001, 32'h2000, 32'h0,        32'h12348001, 1, 0, 4'b1111, 32'h0,        32'hFFFF8001);
      add(1, 0, 3'b100, 32'h1001, 32'h0,        32'h00009A00, 0, 0, 4'b1111, 32'h0,        32'h0000009A);
      add(0, 1, 3'b010, 32'h0050, 32'hDEADBEEF, 32'h0,        3, 0, 4'b1111, 32'hDEADBEEF, 32'h0);
      add(0, 1, 3'b011, 32'h0050, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0);
      add(1, 0, 3'b110, 32'h0040, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0);
      add(0, 1, 3'b100, 32'h0040, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0);
      add(1, 0, 3'b010, 32'h0060, 32'h0,        32'hCAFEF00D, 1, 0, 4'b1111, 32'h0,        32'hCAFEF00D);
      add(1, 0, 3'b001, 32'h0063, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0);
      add(0, 1, 3'b001, 32'h0031, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0);
      add(1, 0, 3'b000, 32'h1002, 32'h0,        32'h007F0000, 0, 0, 4'b1111, 32'h0,        32'h0000007F);
      add(1, 0, 3'b001, 32'h2002, 32'h0,        32'h9001FFFF, 0, 0, 4'b1111, 32'h0,        32'hFFFF9001);

      repeat (2) @(negedge clk);
      tag = "reset";
      chk("busy", busy, 0);       chk("done", done, 0);         chk("error", error, 0);
      chk("mem_req", mem_req, 0); chk("mem_be", mem_be, 0);     chk("load_data", load_data, 0);
      chk("mem_we", mem_we, 0);   chk("mem_addr", mem_addr, 0); chk("mem_wdata", mem_wdata, 0);
      rstN = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         tag = $sformatf("vec%0d", i);
         issue(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].a, vecs[i].sdata);
         if (vecs[i].err) begin
            chk("err_mem_req", mem_req, 0);
            chk("err_done", done, 1);
            chk("err_flag", error, 1);
            chk("err_load_data", load_data, ld_model);
         end else begin
            chk("mem_req", mem_req, 1);
            chk("busy", busy, 1);
            chk("mem_addr", mem_addr, {vecs[i].a[31:2], 2'b00});
            chk("mem_we", mem_we, vecs[i].wr);
            chk("mem_be", mem_be, vecs[i].be);
            if (vecs[i].wr) chk("mem_wdata", mem_wdata, vecs[i].wdata);
            for (int w = 0; w < vecs[i].waitc; w++) begin
               @(negedge clk);
               chk("hold_req", mem_req, 1);
               chk("no_early_done", done, 0);
            end
            ack_with(vecs[i].rdata);
            if (vecs[i].rd) ld_model = vecs[i].ld;
            chk("done", done, 1);
            chk("error", error, 0);
            chk("req_low", mem_req, 0);
            chk("load_data", load_data, ld_model);
         end
         @(negedge clk);
         chk("done_pulse", done, 0);
         chk("idle_busy", busy, 0);
      end

      // start while busy must be ignored
      tag = "busy_start";
      issue(1, 0, 3'b010, 32'h0070, 32'h0);
      start = 1'b1; memWrite = 1'b1; funct3 = 3'b000; addr = 32'h0080; store_data = 32'hFF;
      @(negedge clk);
      start = 1'b0; memWrite = 1'b0;
      chk("addr_kept", mem_addr, 32'h0070);
      chk("we_kept", mem_we, 0);
      ack_with(32'h0BAD_F00D);
      ld_model = 32'h0BAD_F00D;
      chk("done", done, 1);
      chk("load_data", load_data, ld_model);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("no_second_req", mem_req, 0);
      end

      // asynchronous reset mid-request, then a stale ack
      tag = "reset_in_req";
      issue(1, 0, 3'b010, 32'h0090, 32'h0);
      chk("in_req", mem_req, 1);
      rstN = 1'b0;
      #1;
      chk("req_drop", mem_req, 0);
      chk("busy", busy, 0);
      chk("load_data", load_data, 0);
      chk("mem_be", mem_be, 0);
      ld_model = 32'h0;
      @(negedge clk);
      rstN = 1'b1;
      ack_with(32'hFFFF_FFFF);
      chk("stale_done", done, 0);
      chk("stale_req", mem_req, 0);
      chk("stale_busy", busy, 0);
      chk("stale_load", load_data, 0);

`ifdef LSU_TIMEOUT_EN
      tag = "timeout";
      issue(1, 0, 3'b010, 32'h00A0, 32'h0);
      for (int c = 0; c < 4; c++) begin
         chk("req_high", mem_req, 1);
         @(negedge clk);
      end
      chk("req_low", mem_req, 0);
      chk("done", done, 1);
      chk("error", error, 1);
      chk("load_kept", load_data, ld_model);
      @(negedge clk);
      tag = "ack_at_limit";
      issue(1, 0, 3'b010, 32'h00B0, 32'h0);
      repeat (3) @(negedge clk);
      chk("req_high", mem_req, 1);
      ack_with(32'h1357_9BDF);
      ld_model = 32'h1357_9BDF;
      chk("done", done, 1);
      chk("error", error, 0);
      chk("load_data", load_data, ld_model);
      @(negedge clk);
`else
      tag = "no_timeout";
      issue(1, 0, 3'b010, 32'h00A0, 32'h0);
      repeat (100) @(negedge clk);
      chk("req_still_high", mem_req, 1);
      chk("no_done", done, 0);
      ack_with(32'h2468_ACE0);
      ld_model = 32'h2468_ACE0;
      chk("done", done, 1);
      chk("error", error, 0);
      chk("load_data", load_data, ld_model);
      @(negedge clk);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
